ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx.sv | 247 ++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Runs the inhibit / request-to-send / shift / acknowledge sequence on open-drain
// clock and data lines, then reports completion with the device ACK status.
// Optional build macro PS2_TX_RESEND_EN: failed attempts (NACK or timeout) are
// retried up to RETRY_MAX times before done/ack_err is reported.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8,
    parameter int RETRY_MAX      = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INHIBIT  = 3'd1;
    localparam logic [2:0] S_RTS      = 3'd2;
    localparam logic [2:0] S_SHIFT    = 3'd3;
    localparam logic [2:0] S_ACK      = 3'd4;
    localparam logic [2:0] S_IDLEWAIT = 3'd5;

    logic [1:0]  rst_sync_q, rst_sync_d;
    logic        rst_int_n;
    logic [1:0]  clk_sync_q, clk_sync_d;
    logic [1:0]  data_sync_q, data_sync_d;
    logic        clk_filt_q, clk_filt_d;
    logic [31:0] filt_cnt_q, filt_cnt_d;
    logic        clk_fall;

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic        data_oe_q, data_oe_d;
    logic        nack_q, nack_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;
    logic        timed;
    logic        attempt_end;
    logic        attempt_err;

`ifdef PS2_TX_RESEND_EN
    logic [7:0]  retry_q, retry_d;
`else
    // RETRY_MAX only has an effect when retries are built in.
    logic        unused_retry;
    assign unused_retry = (RETRY_MAX > 0);
`endif

    // Reset goes low asynchronously, comes back high two clocks after resetn rises.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) rst_sync_q <= 2'b00;
        else         rst_sync_q <= rst_sync_d;
    end

    assign rst_int_n = rst_sync_q[1];

    // Pad synchronizers and clock glitch filter; a fall is a filtered 1->0 change.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
        data_sync_d = {data_sync_q[0], ps2_data_in};
        clk_filt_d  = clk_filt_q;
        filt_cnt_d  = '0;
        clk_fall    = 1'b0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (filt_cnt_q == 32'(FILTER_LEN - 1)) begin
                clk_filt_d = clk_sync_q[1];
                clk_fall   = clk_filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 32'd1;
            end
        end
    end

    // Transaction FSM: cycle counting, bit shifting, ACK capture and completion.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        byte_d      = byte_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        data_oe_d   = data_oe_q;
        nack_d      = nack_q;
        done_d      = 1'b0;
        ack_err_d   = 1'b0;
        attempt_end = 1'b0;
        attempt_err = 1'b0;
`ifdef PS2_TX_RESEND_EN
        retry_d     = retry_q;
`endif
        // The watchdog only runs while waiting on the device.
        timed = (state_q == S_SHIFT) || (state_q == S_ACK) || (state_q == S_IDLEWAIT);
        if (timed) cnt_d = clk_fall ? '0 : cnt_q + 32'd1;

        case (state_q)
            S_IDLE: begin
                if (tx_valid && tx_ready) begin
                    byte_d   = tx_data;
                    parity_d = ~^tx_data;
                    cnt_d    = '0;
                    state_d  = S_INHIBIT;
`ifdef PS2_TX_RESEND_EN
                    retry_d  = '0;
`endif
                end
            end
            S_INHIBIT: begin
                if (cnt_q == 32'(INHIBIT_CYCLES - 1)) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_RTS;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RTS: begin
                if (cnt_q == 32'(SETUP_CYCLES - 1)) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    shift_d   = byte_q;
                    state_d   = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SHIFT: begin
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        // Stop bit: release data so the device can drive ACK.
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (clk_fall) begin
                    nack_d  = data_sync_q[1];
                    state_d = S_IDLEWAIT;
                end
            end
            S_IDLEWAIT: begin
                if (clk_sync_q[1] && data_sync_q[1]) begin
                    attempt_end = 1'b1;
                    attempt_err = nack_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timed && !clk_fall && cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            attempt_end = 1'b1;
            attempt_err = 1'b1;
        end

        if (attempt_end) begin
            data_oe_d = 1'b0;
            cnt_d     = '0;
`ifdef PS2_TX_RESEND_EN
            if (attempt_err && retry_q < 8'(RETRY_MAX)) begin
                retry_d = retry_q + 8'd1;
                state_d = S_INHIBIT;
            end else begin
                state_d   = S_IDLE;
                done_d    = 1'b1;
                ack_err_d = attempt_err;
            end
`else
            state_d   = S_IDLE;
            done_d    = 1'b1;
            ack_err_d = attempt_err;
`endif
        end
    end

    // Control state; reset releases both lines immediately.
    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            data_oe_q   <= 1'b0;
            nack_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_err_q   <= 1'b0;
`ifdef PS2_TX_RESEND_EN
            retry_q     <= '0;
`endif
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_filt_q  <= clk_filt_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            data_oe_q   <= data_oe_d;
            nack_q      <= nack_d;
            done_q      <= done_d;
            ack_err_q   <= ack_err_d;
`ifdef PS2_TX_RESEND_EN
            retry_q     <= retry_d;
`endif
        end
    end

    // Command byte, shift register and parity are always loaded before use.
    always_ff @(posedge clock) begin
        byte_q   <= byte_d;
        shift_q  <= shift_d;
        parity_q <= parity_d;
    end

    assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_RTS);
    assign ps2_data_oe = data_oe_q;
    assign busy        = (state_q != S_IDLE);
    assign tx_ready    = (state_q == S_IDLE) && !done_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-drain device model
// and a per-cycle protocol/scoreboard checker.
module tb_ps2_host_tx;

    localparam int INH   = 60;
    localparam int SETUP = 10;
    localparam int TO    = 3000;
    localparam int FLEN  = 4;
    localparam int HALF  = 40;
`ifdef PS2_TX_RESEND_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done, ack_err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SETUP),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FLEN),
        .RETRY_MAX     (2)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit err;
        int attempts;
        bit tmo;
    } exp_t;

    exp_t exp_q[$];
    int   sends   = 0;
    int   accepts = 0;

    // Frame as seen on the line at device rising edges: D0..D7, odd parity, stop.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

    // Per-cycle checker: handshake rules, clock-low/setup timing, completions.
    int   oe_run = 0;
    int   shift_run = 0;
    int   attempts_seen = 0;
    bit   prev_done = 1'b0;
    exp_t cur;

    always @(negedge clock) begin
        if (!resetn) begin
            oe_run        = 0;
            shift_run     = 0;
            attempts_seen = 0;
            prev_done     = 1'b0;
        end else begin
            if (tx_valid && tx_ready) accepts++;
            chk("ready_while_busy", int'(tx_ready && busy), 0);
            if (done) chk("ready_at_done", int'(tx_ready), 0);
            if (prev_done) chk("ready_after_done", int'(tx_ready), 1);
            if (!busy) chk("idle_lines", int'({ps2_clk_oe, ps2_data_oe}), 0);
            if (ps2_clk_oe) begin
                oe_run++;
                if (oe_run == 1) attempts_seen++;
                shift_run = 0;
                chk("data_oe_vs_inhibit", int'(ps2_data_oe), int'(oe_run > INH));
            end else begin
                if (oe_run > 0) begin
                    chk("clk_low_len", oe_run, INH + SETUP);
                    oe_run = 0;
                end
                if (busy && ps2_data_oe) shift_run++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("done_ack_err", int'(ack_err), int'(cur.err));
                    chk("attempt_count", attempts_seen, cur.attempts);
                    if (cur.tmo) chk("timeout_len", shift_run, TO);
                end
                attempts_seen = 0;
            end
            prev_done = done;
        end
    end

    task automatic send(input logic [7:0] b, input exp_t e);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        chk("send_ready", int'(ok), 1);
        if (ok) begin
            exp_q.push_back(e);
            sends++;
            tx_data  = b;
            tx_valid = 1'b1;
            @(posedge clock);
            #1;
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_ready(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            #1;
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("txn_end_in_time", int'(ok), 1);
    endtask

    task automatic wait_oe(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (ps2_clk_oe == lvl) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
        end
        if (!ok) chk("wait_clk_oe", 0, 1);
    endtask

    // Device model: clocks nedges falling edges, records data at rising edges,
    // drives ACK low before edge 11 when do_ack is set.
    task automatic device_frame(input bit do_ack, input int nedges, input bit glitch,
                                output logic [9:0] rec, output bit ok);
        rec = '0;
        wait_oe(1'b1, ok);
        if (ok) wait_oe(1'b0, ok);
        if (ok) begin
            repeat (30) @(posedge clock);
            for (int e = 1; e <= nedges; e++) begin
                dev_clk = 1'b0;
                repeat (HALF) @(posedge clock);
                dev_clk = 1'b1;
                if (e <= 10) rec[e-1] = ps2_data_in;
                if (e < nedges) begin
                    if (e == 10) begin
                        repeat (5) @(posedge clock);
                        dev_data = do_ack ? 1'b0 : 1'b1;
                        repeat (HALF - 5) @(posedge clock);
                    end else if (glitch) begin
                        repeat (15) @(posedge clock);
                        dev_clk = 1'b0;
                        repeat (3) @(posedge clock);
                        dev_clk = 1'b1;
                        repeat (HALF - 18) @(posedge clock);
                    end else begin
                        repeat (HALF) @(posedge clock);
                    end
                end
            end
            dev_data = 1'b1;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    logic [9:0] rec;
    bit         ok;
    exp_t       e;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_clk_oe", int'(ps2_clk_oe), 0);
        chk("rst_data_oe", int'(ps2_data_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ack_err", int'(ack_err), 0);
        chk("rst_tx_ready", int'(tx_ready), 1);
        resetn = 1'b1;
        repeat (5) @(posedge clock);
        #1;

        // 0xED acknowledged
        e = '{err: 1'b0, attempts: 1, tmo: 1'b0};
        send(8'hED, e);
        device_frame(1'b1, 11, 1'b0, rec, ok);
        chk("frame_ED", int'(rec), int'(frame_of(8'hED)));
        chk("frame_ED_literal", int'(rec), int'(10'b11_1110_1101));
        wait_ready(500);

        // 0x00 NACKed by the device
        e = '{err: 1'b1, attempts: ATTEMPTS, tmo: 1'b0};
        send(8'h00, e);
        for (int a = 0; a < ATTEMPTS; a++) begin
            device_frame(1'b0, 11, 1'b0, rec, ok);
            chk("frame_00", int'(rec), int'(frame_of(8'h00)));
            chk("parity_00_literal", int'(rec[8]), 1);
        end
        wait_ready(500);

        // 0xFF with a silent device: watchdog ends the transaction
        e = '{err: 1'b1, attempts: ATTEMPTS, tmo: 1'b1};
        send(8'hFF, e);
        wait_ready(ATTEMPTS * (TO + 200));

        // 0xED with a competing 0xF4 request while busy
        e = '{err: 1'b0, attempts: 1, tmo: 1'b0};
        send(8'hED, e);
        fork
            device_frame(1'b1, 11, 1'b0, rec, ok);
            begin
                repeat (200) @(posedge clock);
                #1;
                tx_data  = 8'hF4;
                tx_valid = 1'b1;
                repeat (400) @(posedge clock);
                #1;
                tx_valid = 1'b0;
            end
        join
        chk("frame_ED_busy", int'(rec), int'(frame_of(8'hED)));
        wait_ready(500);

        // Reset during RTS: both lines must release at once
        e = '{err: 1'b0, attempts: 1, tmo: 1'b0};
        send(8'hED, e);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ps2_data_oe) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        chk("rts_reached", int'(ok), 1);
        chk("rts_both_oe", int'({ps2_clk_oe, ps2_data_oe}), 3);
        #1 resetn = 1'b0;
        #1;
        chk("rts_rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("rts_rst_busy", int'(busy), 0);
        void'(exp_q.pop_back());
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        repeat (5) @(posedge clock);
        #1;

        // Reset after the 4th falling edge
        e = '{err: 1'b0, attempts: 1, tmo: 1'b0};
        send(8'hED, e);
        device_frame(1'b1, 4, 1'b0, rec, ok);
        chk("busy_mid_frame", int'(busy), 1);
        repeat (3) @(posedge clock);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(tx_ready), 1);
        void'(exp_q.pop_back());
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        repeat (5) @(posedge clock);
        #1;

        e = '{err: 1'b0, attempts: 1, tmo: 1'b0};
        send(8'hED, e);
        device_frame(1'b1, 11, 1'b0, rec, ok);
        chk("frame_ED_after_rst", int'(rec), int'(frame_of(8'hED)));
        wait_ready(500);

        // 3-cycle clock glitches in every high phase
        e = '{err: 1'b0, attempts: 1, tmo: 1'b0};
        send(8'hED, e);
        device_frame(1'b1, 11, 1'b1, rec, ok);
        chk("frame_ED_glitch", int'(rec), int'(frame_of(8'hED)));
        wait_ready(500);

        repeat (5) @(posedge clock);
        #1;
        chk("accept_count", accepts, sends);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
